// File: rtl/img_pkg.sv
// Shared image-pipeline constants: default geometry, threshold and RGB channel placement.
package img_pkg;

    localparam int ROW       = 256;
    localparam int WIDTH     = 8;
    localparam int PIX_BITS  = 3 * WIDTH;
    localparam int THRESHOLD = 128;

    // Channel lanes inside a packed pixel, lowest lane first (B is the low byte).
    typedef enum logic [1:0] {
        CH_B = 2'd0,
        CH_G = 2'd1,
        CH_R = 2'd2
    } chan_e;

    localparam int R_LSB = 2 * WIDTH;
    localparam int G_LSB = WIDTH;
    localparam int B_LSB = 0;

    function automatic int chan_lsb(input chan_e ch, input int width);
        return int'(ch) * width;
    endfunction

endpackage

// File: rtl/pixel_threshold.sv
// Combinational per-pixel binarisation: white when R+G+B reaches 3*THRESHOLD, else black.
module pixel_threshold #(
    parameter int WIDTH     = img_pkg::WIDTH,
    parameter int THRESHOLD = img_pkg::THRESHOLD
) (
    input  logic [3*WIDTH-1:0] i_pixel,
    output logic [3*WIDTH-1:0] o_pixel
);
    import img_pkg::*;

    // Two extra bits hold the sum of three full-scale channels without overflow.
    localparam int             SW    = WIDTH + 2;
    localparam logic [SW-1:0]  LIMIT = SW'(3 * THRESHOLD);

    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_b;
    logic [SW-1:0]    w_sum;
    logic             w_white;

    assign w_r     = i_pixel[chan_lsb(CH_R, WIDTH) +: WIDTH];
    assign w_g     = i_pixel[chan_lsb(CH_G, WIDTH) +: WIDTH];
    assign w_b     = i_pixel[chan_lsb(CH_B, WIDTH) +: WIDTH];
    assign w_sum   = SW'(w_r) + SW'(w_g) + SW'(w_b);
    assign w_white = (w_sum >= LIMIT);
    assign o_pixel = {(3 * WIDTH){w_white}};

endmodule

// File: rtl/binary_threshold_filter.sv
// Row-parallel binary threshold stage: ROW independent pixel comparators feeding one
// load-enabled output row register.
module binary_threshold_filter #(
    parameter int ROW       = img_pkg::ROW,
    parameter int WIDTH     = img_pkg::WIDTH,
    parameter int THRESHOLD = img_pkg::THRESHOLD
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SET,
    input  logic [ROW*WIDTH*3-1:0] row_in,
    output logic [ROW*WIDTH*3-1:0] row_out
);
    localparam int PB = 3 * WIDTH;

    logic [ROW*PB-1:0] w_row_bw;
    logic [ROW*PB-1:0] r_row_out;

    generate
        for (genvar gi = 0; gi < ROW; gi++) begin : g_pix
            pixel_threshold #(
                .WIDTH     (WIDTH),
                .THRESHOLD (THRESHOLD)
            ) u_pix (
                .i_pixel (row_in[gi*PB +: PB]),
                .o_pixel (w_row_bw[gi*PB +: PB])
            );
        end
    endgenerate

    // SET low holds the previous row; the incoming row is simply dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_row_out <= '0;
        end else if (SET) begin
            r_row_out <= w_row_bw;
        end
    end

    assign row_out = r_row_out;

endmodule

// File: tb/tb_binary_threshold_filter.sv
// Directed bench for binary_threshold_filter: reset, boundaries, mapping, hold, streaming.
module tb_binary_threshold_filter;

    localparam int ROW = 256;
    localparam int PB  = 24;
    localparam int RB  = ROW * PB;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          SET = 1'b0;
    logic [RB-1:0] row_in = '0;
    logic [RB-1:0] row_out;
    logic [RB-1:0] row_out_t0;

    int total = 0;
    int bad   = 0;

    binary_threshold_filter #(.ROW(ROW), .WIDTH(8), .THRESHOLD(128)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SET     (SET),
        .row_in  (row_in),
        .row_out (row_out)
    );

    binary_threshold_filter #(.ROW(ROW), .WIDTH(8), .THRESHOLD(0)) dut_t0 (
        .CLK     (CLK),
        .RST     (RST),
        .SET     (SET),
        .row_in  (row_in),
        .row_out (row_out_t0)
    );

    always #5 CLK = ~CLK;

    function automatic logic [RB-1:0] fill(input logic [23:0] p);
        logic [RB-1:0] r;
        for (int k = 0; k < ROW; k++) r[k*PB +: PB] = p;
        return r;
    endfunction

    // Index of the first differing pixel, used only to keep FAIL lines short.
    function automatic int first_diff(input logic [RB-1:0] a, input logic [RB-1:0] b);
        for (int k = 0; k < ROW; k++) if (a[k*PB +: PB] !== b[k*PB +: PB]) return k;
        return -1;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [RB-1:0] exp_row;
        int            idx;
        exp_row = '0;
        RST     = 1'b0;
        SET     = 1'b1;
        row_in  = fill(24'hFFFFFF);
        #1;
        total++;
        if (row_out !== exp_row) begin
            idx = first_diff(row_out, exp_row);
            $display("FAIL reset_immediate pix%0d got=%h want=%h", idx, row_out[idx*PB +: PB], exp_row[idx*PB +: PB]);
            bad++;
        end
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (row_out !== exp_row) begin
                idx = first_diff(row_out, exp_row);
                $display("FAIL reset_hold c%0d pix%0d got=%h want=%h", c, idx, row_out[idx*PB +: PB], exp_row[idx*PB +: PB]);
                bad++;
            end
        end
        $display("reset: row_out held at zero while RST low");
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_uniform();
        logic [23:0]   pin  [3] = '{24'h808080, 24'h7F8080, 24'hFFFFFF};
        logic [23:0]   pexp [3] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        logic [RB-1:0] exp_row;
        int            idx;
        for (int t = 0; t < 3; t++) begin
            SET     = 1'b1;
            row_in  = fill(pin[t]);
            exp_row = fill(pexp[t]);
            step();
            total++;
            if (row_out !== exp_row) begin
                idx = first_diff(row_out, exp_row);
                $display("FAIL uniform_%h pix%0d got=%h want=%h", pin[t], idx, row_out[idx*PB +: PB], exp_row[idx*PB +: PB]);
                bad++;
            end
            $display("uniform: in=%h out_pix0=%h", pin[t], row_out[PB-1:0]);
        end
    endtask

    task automatic test_mixed();
        logic [RB-1:0] in_row;
        logic [RB-1:0] exp_row;
        int            idx;
        in_row  = fill(24'hC8C8C8);
        exp_row = fill(24'hFFFFFF);
        in_row[0*PB +: PB]   = 24'hFF0000;
        exp_row[0*PB +: PB]  = 24'h000000;
        in_row[1*PB +: PB]   = 24'h00FFFF;
        exp_row[1*PB +: PB]  = 24'hFFFFFF;
        in_row[255*PB +: PB] = 24'h646464;
        exp_row[255*PB +: PB] = 24'h000000;
        SET    = 1'b1;
        row_in = in_row;
        step();
        total++;
        if (row_out !== exp_row) begin
            idx = first_diff(row_out, exp_row);
            $display("FAIL mixed pix%0d got=%h want=%h", idx, row_out[idx*PB +: PB], exp_row[idx*PB +: PB]);
            bad++;
        end
        $display("mixed: p0=%h p1=%h p255=%h", row_out[0 +: PB], row_out[PB +: PB], row_out[255*PB +: PB]);
    endtask

    task automatic test_hold();
        logic [RB-1:0] white;
        logic [RB-1:0] black;
        int            idx;
        white  = fill(24'hFFFFFF);
        black  = '0;
        SET    = 1'b1;
        row_in = fill(24'hC8C8C8);
        step();
        SET    = 1'b0;
        row_in = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (row_out !== white) begin
                idx = first_diff(row_out, white);
                $display("FAIL hold c%0d pix%0d got=%h want=%h", c, idx, row_out[idx*PB +: PB], white[idx*PB +: PB]);
                bad++;
            end
        end
        SET = 1'b1;
        step();
        total++;
        if (row_out !== black) begin
            idx = first_diff(row_out, black);
            $display("FAIL hold_release pix%0d got=%h want=%h", idx, row_out[idx*PB +: PB], black[idx*PB +: PB]);
            bad++;
        end
        $display("hold: held white 5 cycles, reload gave pix0=%h", row_out[PB-1:0]);
    endtask

    task automatic test_toggle();
        logic [23:0]   pin  [4] = '{24'hC8C8C8, 24'h101010, 24'h101010, 24'hC8C8C8};
        logic          sin  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [23:0]   pexp [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
        logic [RB-1:0] exp_row;
        int            idx;
        for (int t = 0; t < 4; t++) begin
            SET     = sin[t];
            row_in  = fill(pin[t]);
            exp_row = fill(pexp[t]);
            step();
            total++;
            if (row_out !== exp_row) begin
                idx = first_diff(row_out, exp_row);
                $display("FAIL toggle_%0d pix%0d got=%h want=%h", t, idx, row_out[idx*PB +: PB], exp_row[idx*PB +: PB]);
                bad++;
            end
            $display("toggle: SET=%0b in=%h out_pix0=%h", sin[t], pin[t], row_out[PB-1:0]);
        end
    endtask

    task automatic test_threshold_zero();
        logic [RB-1:0] white;
        logic [RB-1:0] black;
        int            idx;
        white  = fill(24'hFFFFFF);
        black  = '0;
        SET    = 1'b1;
        row_in = '0;
        step();
        total++;
        if (row_out_t0 !== white) begin
            idx = first_diff(row_out_t0, white);
            $display("FAIL thr0_white pix%0d got=%h want=%h", idx, row_out_t0[idx*PB +: PB], white[idx*PB +: PB]);
            bad++;
        end
        total++;
        if (row_out !== black) begin
            idx = first_diff(row_out, black);
            $display("FAIL thr128_zero_in pix%0d got=%h want=%h", idx, row_out[idx*PB +: PB], black[idx*PB +: PB]);
            bad++;
        end
        $display("thr0: zero row -> t0 pix0=%h t128 pix0=%h", row_out_t0[PB-1:0], row_out[PB-1:0]);
    endtask

    task automatic test_back_to_back();
        logic [RB-1:0] exp_row;
        logic [7:0]    v;
        int            idx;
        int            nbad;
        nbad = 0;
        SET  = 1'b1;
        for (int n = 0; n < 256; n++) begin
            v       = 8'(n);
            row_in  = fill({v, v, v});
            exp_row = (n >= 128) ? fill(24'hFFFFFF) : '0;
            step();
            total++;
            if (row_out !== exp_row) begin
                idx = first_diff(row_out, exp_row);
                $display("FAIL stream_row%0d pix%0d got=%h want=%h", n, idx, row_out[idx*PB +: PB], exp_row[idx*PB +: PB]);
                bad++;
                nbad++;
            end
            if (n == 200) begin
                #1 RST = 1'b0;
                #1;
                total++;
                if (row_out !== '0) begin
                    idx = first_diff(row_out, '0);
                    $display("FAIL stream_async_reset pix%0d got=%h want=000000", idx, row_out[idx*PB +: PB]);
                    bad++;
                end
                #2 RST = 1'b1;
                $display("stream: async reset pulse at row 200, out_pix0=%h", row_out[PB-1:0]);
            end
        end
        $display("stream: 256 rows checked, %0d row errors", nbad);
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_mixed();
        test_hold();
        test_toggle();
        test_threshold_zero();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/binary_threshold_filter.md
Name: binary_threshold_filter

Overview:
- Row-parallel binary threshold stage of the image-processing pipeline.
- Each clock it takes one full image row of packed RGB pixels. Every pixel is replaced with pure white (all channels max) or pure black (all channels zero), based on its channel sum versus a threshold.
- Output is one registered row; upstream is the raw-image row feeder, downstream is the row writer/sink.

Parameters:
- ROW, 256, pixels per row processed in parallel.
- WIDTH, 8, bits per colour channel.
- THRESHOLD, 128, per-channel-average threshold (0..2^WIDTH-1).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- SET  input  1  load enable; 1 = capture and threshold row_in this cycle, 0 = hold.
- row_in  input  ROW*WIDTH*3  packed input row.
  - Pixel k occupies bits [24k+23:24k] (for WIDTH=8).
  - Within a pixel: R = upper byte, G = middle byte, B = lower byte.
- row_out  output  ROW*WIDTH*3  packed thresholded row; same pixel and channel layout as row_in.

Behaviour:
- Reset: RST low forces row_out to all zeros immediately, without waiting for a clock edge, and holds it while RST is low. Normal operation resumes on the first rising CLK edge after RST returns high.
- Per pixel k, combinational stage:
  - sum_k = R_k + G_k + B_k, zero-extended to WIDTH+2 bits (10 bits default); no overflow possible.
  - limit = 3*THRESHOLD, computed at elaboration at WIDTH+2 bits.
  - bit_k = 1 when sum_k >= limit, else 0.
  - Output pixel = {3*WIDTH{bit_k}}: 0xFFFFFF (white) or 0x000000 (black).
- Register stage:
  - On rising CLK with RST high and SET=1: row_out <= thresholded row_in.
  - With SET=0: row_out holds its previous value; row_in is ignored.
- Latency: exactly 1 clock from the SET=1 sample edge to row_out valid. Throughput: one row per clock, no back-pressure.
- Positional invariance: pixel k of the output derives only from pixel k of the input. No neighbourhood, no reordering, no channel swap.
- Boundary conditions:
  - sum exactly equal to limit -> white.
  - sum = limit-1 -> black.
  - THRESHOLD=0 -> all white.
  - All channels max (sum 765) -> white for any legal THRESHOLD.
- Reset asserted mid-stream: row_out clears at once; the next row captured after release is processed normally; no residual state.
- SET toggling every cycle: only rows sampled with SET=1 propagate; others are dropped.
- No other state: no counters, no FSM, no valid flag.

Decomposition:
- Shared package (img_pkg): ROW=256, WIDTH=8, PIX_BITS=3*WIDTH, default THRESHOLD=128, and channel-slice offsets (R, G, B bit positions).
- Sub-module pixel_threshold:
  - Parameters WIDTH, THRESHOLD.
  - Input: one 3*WIDTH pixel.
  - Output: 3*WIDTH black/white pixel, combinational.
- Top instantiates ROW copies via a generate loop and adds the SET-gated, async-reset output register.

Test Plan:
- Reset: drive RST=0 with row_in all 0xFF and SET=1 -> row_out is all 0 immediately and remains 0 across clock edges while RST=0.
- Uniform rows (THRESHOLD=128, RST=1, SET=1):
  - Every pixel 0x808080 (sum 384 = limit) -> one clock later every pixel 0xFFFFFF.
  - Every pixel 0x7F8080 (sum 383) -> every pixel 0x000000.
- Mixed row, SET=1:
  - Pixel 0 = 0xFF0000 (sum 255), pixel 1 = 0x00FFFF (510), pixel 255 = 0x646464 (300), rest 0xC8C8C8 (600).
  - Next clock: pixel 0 black, pixel 1 white, pixel 255 black, rest white. Verifies positional mapping and R/G/B lane independence.
- Hold: capture an all-white row, then set SET=0 and drive all-zero row_in for 5 clocks -> row_out remains all 0xFFFFFF. Raise SET=1 -> next clock row_out is all 0x000000.
- Streaming: 256 consecutive rows with SET=1, row n having every pixel = {n,n,n}.
  - row_out at cycle n+1: black for n<128, white for n>=128.
  - Exactly 1-cycle latency, no dropped rows.
- Reset mid-stream: during the streaming test, pulse RST low for 3 ns between edges -> row_out drops to 0 asynchronously. The first row after release appears correctly one clock later.
